// File: rtl/vx_commit_merge.sv
// Commit-side merge: per-unit result FIFOs, round-robin merge, outstanding tracking.
// Optional perf counters (perf_stalls, perf_commits) under `COMMIT_MERGE_PERF_EN.
module vx_commit_merge #(
    parameter int NUM_UNITS  = 4,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_UNITS-1:0]           disp_fire,
    input  logic [NUM_UNITS-1:0]           res_valid,
    input  logic [NUM_UNITS*DATA_W-1:0]    res_data,
    output logic [NUM_UNITS-1:0]           res_ready,
    output logic                           commit_valid,
    output logic [DATA_W-1:0]              commit_data,
    output logic [$clog2(NUM_UNITS)-1:0]   commit_unit,
    input  logic                           commit_ready,
    output logic                           no_pending,
`ifdef COMMIT_MERGE_PERF_EN
    output logic [31:0]                    perf_stalls,
    output logic [31:0]                    perf_commits,
`endif
    output logic                           cnt_err
);

    localparam int UW = $clog2(NUM_UNITS);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {ST_IDLE, ST_HOLD} arb_state_t;

    arb_state_t          r_state;
    logic [UW-1:0]       r_hold_unit;
    logic [UW-1:0]       r_rr_ptr;
    logic                r_cnt_err;
    logic [NUM_UNITS-1:0] r_full;

    logic [DATA_W-1:0]   r_mem   [NUM_UNITS][FIFO_DEPTH];
    logic [AW-1:0]       r_wp    [NUM_UNITS];
    logic [AW-1:0]       r_rp    [NUM_UNITS];
    logic [AW:0]         r_count [NUM_UNITS];
    logic [CNT_W-1:0]    r_cnt   [NUM_UNITS];

    logic [AW:0]         w_fcnt_nxt [NUM_UNITS];
    logic [CNT_W-1:0]    w_cnt_nxt  [NUM_UNITS];
    logic [NUM_UNITS-1:0] w_nonempty;
    logic [NUM_UNITS-1:0] w_wr;
    logic [NUM_UNITS-1:0] w_rd;
    logic [NUM_UNITS-1:0] w_err;
    logic [2*NUM_UNITS-1:0] w_dbl;
    logic [NUM_UNITS-1:0] w_rot;
    logic [UW:0]         w_off;
    logic [UW:0]         w_sum;
    logic [UW-1:0]       w_search;
    logic [UW-1:0]       w_grant;
    logic [UW-1:0]       w_next_rr;
    logic                w_valid;
    logic                w_commit;
    logic                w_no_pend;

    always_comb begin
        w_nonempty = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_nonempty[i] = (r_count[i] != '0);
        end
    end

    // Rotate so bit k is unit (rr_ptr + k) mod N; lowest set bit wins.
    assign w_dbl = {w_nonempty, w_nonempty} >> r_rr_ptr;
    assign w_rot = w_dbl[NUM_UNITS-1:0];

    always_comb begin
        w_off = '0;
        for (int k = NUM_UNITS - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = (UW+1)'(k);
        end
    end

    assign w_sum    = {1'b0, r_rr_ptr} + w_off;
    assign w_search = (w_sum >= (UW+1)'(NUM_UNITS))
                    ? UW'(w_sum - (UW+1)'(NUM_UNITS))
                    : w_sum[UW-1:0];

    assign w_valid   = |w_nonempty;
    assign w_grant   = (r_state == ST_HOLD) ? r_hold_unit : w_search;
    assign w_commit  = w_valid & commit_ready;
    assign w_next_rr = (w_grant == UW'(NUM_UNITS - 1)) ? '0 : w_grant + 1'b1;

    assign res_ready    = ~r_full;
    assign commit_valid = w_valid;
    assign commit_unit  = w_valid ? w_grant : '0;
    assign commit_data  = w_valid ? r_mem[w_grant][r_rp[w_grant]] : '0;
    assign cnt_err      = r_cnt_err;
    assign no_pending   = w_no_pend;

    always_comb begin
        w_wr = '0;
        w_rd = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_wr[i] = res_valid[i] & ~r_full[i];
            w_rd[i] = w_commit & (w_grant == UW'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_fcnt_nxt[i] = r_count[i] + (AW+1)'(w_wr[i]) - (AW+1)'(w_rd[i]);
        end
    end

    // Saturating outstanding counters; simultaneous inc/dec cancels.
    always_comb begin
        w_err = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (disp_fire[i] && !w_rd[i]) begin
                if (r_cnt[i] == '1) w_err[i] = 1'b1;
                else                w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end else if (w_rd[i] && !disp_fire[i]) begin
                if (r_cnt[i] == '0) w_err[i] = 1'b1;
                else                w_cnt_nxt[i] = r_cnt[i] - 1'b1;
            end
        end
    end

    always_comb begin
        w_no_pend = 1'b1;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (r_cnt[i] != '0) w_no_pend = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (w_wr[i]) r_mem[i][r_wp[i]] <= res_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full <= '0;
            for (int i = 0; i < NUM_UNITS; i++) begin
                r_wp[i]    <= '0;
                r_rp[i]    <= '0;
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (w_wr[i]) r_wp[i] <= r_wp[i] + 1'b1;
                if (w_rd[i]) r_rp[i] <= r_rp[i] + 1'b1;
                r_count[i] <= w_fcnt_nxt[i];
                r_full[i]  <= (w_fcnt_nxt[i] == (AW+1)'(FIFO_DEPTH));
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt_err <= 1'b0;
            for (int i = 0; i < NUM_UNITS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_cnt_err <= r_cnt_err | (|w_err);
            for (int i = 0; i < NUM_UNITS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // Grant is frozen while stalled so the presented beat never changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_hold_unit <= '0;
            r_rr_ptr    <= '0;
        end else if (w_commit) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= w_next_rr;
        end else if (w_valid) begin
            r_state     <= ST_HOLD;
            r_hold_unit <= w_grant;
        end
    end

`ifdef COMMIT_MERGE_PERF_EN
    logic [31:0] r_perf_stalls;
    logic [31:0] r_perf_commits;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_stalls  <= '0;
            r_perf_commits <= '0;
        end else begin
            if (w_valid && !commit_ready) r_perf_stalls <= r_perf_stalls + 1'b1;
            if (w_commit) r_perf_commits <= r_perf_commits + 1'b1;
        end
    end

    assign perf_stalls  = r_perf_stalls;
    assign perf_commits = r_perf_commits;
`endif

endmodule

// File: tb/tb_vx_commit_merge.sv
// Bench for vx_commit_merge: directed scenarios plus random traffic vs a queue model.
module tb_vx_commit_merge;

    localparam int N     = 4;
    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int CW    = 2;
    localparam int CMAX  = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      disp_fire = '0;
    logic [N-1:0]      res_valid = '0;
    logic [N*DW-1:0]   res_data = '0;
    logic [N-1:0]      res_ready;
    logic              commit_valid;
    logic [DW-1:0]     commit_data;
    logic [1:0]        commit_unit;
    logic              commit_ready = 1'b0;
    logic              no_pending;
    logic              cnt_err;
`ifdef COMMIT_MERGE_PERF_EN
    logic [31:0]       perf_stalls;
    logic [31:0]       perf_commits;
`endif

    vx_commit_merge #(
        .NUM_UNITS (N),
        .DATA_W    (DW),
        .FIFO_DEPTH(DEPTH),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .disp_fire   (disp_fire),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_ready   (res_ready),
        .commit_valid(commit_valid),
        .commit_data (commit_data),
        .commit_unit (commit_unit),
        .commit_ready(commit_ready),
        .no_pending  (no_pending),
`ifdef COMMIT_MERGE_PERF_EN
        .perf_stalls (perf_stalls),
        .perf_commits(perf_commits),
`endif
        .cnt_err     (cnt_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mq [N][$];
    int            m_rr;
    bit            m_hold;
    int            m_hu;
    int            mcnt [N];
    bit            merr;
    logic [DW-1:0] hd;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_grant();
        if (m_hold) return m_hu;
        for (int k = 0; k < N; k++) begin
            if (mq[(m_rr + k) % N].size() != 0) return (m_rr + k) % N;
        end
        return 0;
    endfunction

    task automatic check_all();
        bit v = 0;
        bit np = 1;
        logic [N-1:0] rdy;
        for (int i = 0; i < N; i++) begin
            if (mq[i].size() != 0) v = 1;
            if (mcnt[i] != 0) np = 0;
            rdy[i] = (mq[i].size() < DEPTH);
        end
        chk("commit_valid", commit_valid, v);
        if (v) begin
            int g = m_grant();
            chk("commit_unit", commit_unit, g);
            chk("commit_data", commit_data, mq[g][0]);
        end
        chk("res_ready", res_ready, rdy);
        chk("no_pending", no_pending, np);
        chk("cnt_err", cnt_err, merr);
    endtask

    task automatic model_edge();
        bit v = 0;
        bit cm;
        int g;
        bit [N-1:0] acc;
        for (int i = 0; i < N; i++) begin
            if (mq[i].size() != 0) v = 1;
            acc[i] = res_valid[i] && (mq[i].size() < DEPTH);
        end
        g  = m_grant();
        cm = v && commit_ready;
        if (cm) begin
            mq[g].delete(0);
            m_rr   = (g + 1) % N;
            m_hold = 0;
        end else if (v) begin
            m_hold = 1;
            m_hu   = g;
        end
        for (int i = 0; i < N; i++) begin
            if (acc[i]) mq[i].push_back(res_data[i*DW +: DW]);
        end
        for (int i = 0; i < N; i++) begin
            bit inc = disp_fire[i];
            bit dec = cm && (g == i);
            if (inc && !dec) begin
                if (mcnt[i] == CMAX) merr = 1;
                else mcnt[i]++;
            end else if (dec && !inc) begin
                if (mcnt[i] == 0) merr = 1;
                else mcnt[i]--;
            end
        end
    endtask

    task automatic step(input logic [N-1:0] df, input logic [N-1:0] rv,
                        input logic cr);
        check_all();
        disp_fire    = df;
        res_valid    = rv;
        commit_ready = cr;
        for (int i = 0; i < N; i++) begin
            res_data[i*DW +: DW] = {$urandom, $urandom};
        end
        model_edge();
        @(posedge clk);
        @(negedge clk);
        disp_fire = '0;
        res_valid = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mq[i].delete();
            mcnt[i] = 0;
        end
        m_rr   = 0;
        m_hold = 0;
        m_hu   = 0;
        merr   = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_clear();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, commit_valid, 0);
        chk({tag, "_data"}, commit_data, 0);
        chk({tag, "_unit"}, commit_unit, 0);
        chk({tag, "_ready"}, res_ready, 4'hF);
        chk({tag, "_np"}, no_pending, 1);
        chk({tag, "_err"}, cnt_err, 0);
    endtask

    initial begin
        model_clear();
        do_reset();
        chk_reset_vals("rst");

        // Round-robin order across one entry per unit
        step(4'hF, 4'hF, 1'b1);
        for (int k = 0; k < N; k++) begin
            chk("rr_valid", commit_valid, 1);
            chk("rr_unit", commit_unit, k);
            step('0, '0, 1'b1);
        end
        chk("rr_empty", commit_valid, 0);
        check_all();

        // Backpressure hold; a late unit-0 entry must not steal the grant
        do_reset();
        step(4'b0111, 4'b0110, 1'b0);
        hd = mq[1][0];
        for (int k = 0; k < 5; k++) begin
            chk("hold_unit", commit_unit, 1);
            chk("hold_data", commit_data, hd);
            step('0, (k == 0) ? 4'b0001 : 4'b0000, 1'b0);
        end
        chk("rel_unit1", commit_unit, 1);
        step('0, '0, 1'b1);
        chk("rel_unit2", commit_unit, 2);
        step('0, '0, 1'b1);
        chk("rel_unit0", commit_unit, 0);
        step('0, '0, 1'b1);
        chk("rel_empty", commit_valid, 0);

        // FIFO full on unit 3
        do_reset();
        for (int k = 0; k < 5; k++) begin
            if (k == 4) chk("full_rdy3", res_ready[3], 0);
            step((k < 3) ? 4'b1000 : 4'b0000, 4'b1000, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            chk("full_unit", commit_unit, 3);
            step((k == 0) ? 4'b1000 : 4'b0000, '0, 1'b1);
            if (k == 0) chk("full_rdy_rise", res_ready[3], 1);
        end
        chk("full_drained", commit_valid, 0);
        check_all();

        // Outstanding tracking on unit 0
        do_reset();
        for (int k = 0; k < 3; k++) step(4'b0001, 4'b0001, 1'b0);
        chk("np_busy", no_pending, 0);
        step(4'b0000, 4'b0001, 1'b1);
        step(4'b0001, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        chk("np_before_last", no_pending, 0);
        step(4'b0000, 4'b0000, 1'b1);
        chk("np_after_last", no_pending, 1);
        chk("np_no_err", cnt_err, 0);

        // Underflow on unit 2
        do_reset();
        step('0, 4'b0100, 1'b1);
        step('0, '0, 1'b1);
        chk("err_under", cnt_err, 1);
        chk("err_under_np", no_pending, 1);
        step('0, '0, 1'b1);
        chk("err_sticky", cnt_err, 1);

        // Saturation on unit 1 (CNT_W = 2)
        do_reset();
        for (int k = 0; k < 4; k++) step(4'b0010, '0, 1'b0);
        chk("err_sat", cnt_err, 1);
        for (int k = 0; k < 3; k++) step('0, 4'b0010, 1'b0);
        step('0, '0, 1'b1);
        step('0, '0, 1'b1);
        chk("sat_np_busy", no_pending, 0);
        step('0, '0, 1'b1);
        chk("sat_np_done", no_pending, 1);

        // Asynchronous reset mid-stream
        do_reset();
        step(4'hF, 4'hF, 1'b0);
        step(4'b0011, 4'b0011, 1'b0);
        chk("ar_valid_pre", commit_valid, 1);
        #2 reset = 1'b0;
        #1 chk_reset_vals("ar");
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        for (int k = 0; k < 3; k++) begin
            chk("ar_no_stale", commit_valid, 0);
            step('0, '0, 1'b1);
        end

        // Random traffic against the model
        do_reset();
        repeat (400) begin
            step(4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
        end
        check_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
